j_acc_shifter_mx_cell: RTL and testbench
========================================

Name: j_acc_shifter_MX_cell

Overview:
- 32-lane SRAM-to-serial shifter: reads 32-bit words from one shared SRAM read port and streams them out bit-serially, one bit per lane per cycle.
- Mirror of the 32-lane deshifter cell, which collects serial bits and writes words to SRAM.
- Sits between activation/weight SRAM and the bit-serial systolic array inputs.
- Lane i is staggered i cycles behind lane 0.

Parameters:
- SRAM_DEPTH, 256*256*4, SRAM depth in 32-bit words.
- SRAM_ADDR_W, clog2(SRAM_DEPTH), SRAM address width.

Ports:
- clk  in  1  clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- sram_en  out  1  read strobe; one read per asserted cycle.
- sram_addr  out  SRAM_ADDR_W  read address, valid when sram_en=1.
- sram_rdata  in  32  read data, valid exactly 1 cycle after sram_en.
- shift_start  in  1  start pulse, sampled only in IDLE.
- shift_start_o  out  1  shift_start delayed 32 cycles, for chaining the next cell.
- shift_idle  out  1  high when IDLE.
- start_addr  in  SRAM_ADDR_W*32  per-lane base address; lane i at [i*SRAM_ADDR_W +: SRAM_ADDR_W].
- img_size  in  SRAM_ADDR_W  words per lane (N).
- serial_out  out  32  per-lane data bit.
- serial_en  out  32  per-lane bit-valid.

Behaviour:
- Reset values: sram_en=0, sram_addr=0, shift_idle=1, shift_start_o=0, serial_out=0, serial_en=0. All lane shift registers and bit counters are cleared, and the FSM goes to IDLE.
- Reset mid-operation aborts on the next edge with no further SRAM reads.
- start_addr and img_size are latched at start. Later changes have no effect until the next start.
- FSM states:
  - IDLE: when shift_start=1 and N≠0, go to FETCH with lane_sel=0 and word_cnt=0. When N=0, stay IDLE and issue no reads.
  - FETCH: every cycle, register sram_en=1 and sram_addr=start_addr[lane_sel]+word_cnt (mod 2^SRAM_ADDR_W, wraps silently). Then lane_sel++; at lane_sel=31, lane_sel wraps to 0 and word_cnt++. After the fetch for lane 31, word N-1, go to DRAIN.
  - DRAIN: sram_en=0. Wait until lane 31 shifts out its last bit, then go to IDLE.
- shift_start while not IDLE is ignored.
- Timing: cycle 0 is the cycle in which shift_start is sampled in IDLE.
  - Lane i, word k: sram_en=1 in cycle 1+i+32k.
  - rdata is captured into lane i's 32-bit shift register at the end of cycle 2+i+32k.
  - serial_out[i] carries bits 0..31, LSB first, in cycles 3+i+32k .. 34+i+32k, with serial_en[i]=1.
- Each lane stream is gapless across words: the next load coincides with the shift register emptying. No stall or backpressure exists.
- serial_en[i] is high exactly while lane i's bit counter is non-zero. When serial_en[i]=0, serial_out[i]=0.
- shift_idle falls in cycle 1 and rises in cycle 32N+34.
- One SRAM read per cycle in FETCH, exactly 32N reads total.
- shift_start_o: 32-stage shift register of shift_start, independent of the FSM. It pulses even if the start was ignored or N=0.

Test Plan:
- N=1, lane i base=i*16, SRAM[i*16]=0xA5A5_0000|i, start at cycle 0:
  - sram_en high in cycles 1..32 with addresses 0,16,..,496.
  - Lane 0 emits LSB-first 0x00 00 A5 A5 pattern in cycles 3..34; lane 31 in cycles 34..65.
  - shift_idle=1 at cycle 66.
- N=2, lane 0 words 0xFFFFFFFF then 0x00000001:
  - serial_en[0] high continuously in cycles 3..66.
  - serial_out[0]=1 in cycles 3..34 and 35; 0 in cycles 36..66.
  - 64 reads total.
- Address wrap: start_addr lane 5 = 2^SRAM_ADDR_W-1, N=2 -> lane 5 reads addresses 2^SRAM_ADDR_W-1 then 0.
- shift_start pulsed again at cycle 10 and img_size changed at cycle 10 -> ignored; traffic identical to the single-start case.
- Reset asserted at cycle 20 of an N=4 run:
  - Next cycle: sram_en=0, serial_en=0, shift_idle=1.
  - A fresh start afterwards behaves as the first scenario.
- img_size=0 with start -> no sram_en, shift_idle stays 1, shift_start_o pulses once at cycle 32.

Source files
------------

// File: rtl/j_acc_shifter_mx_cell_if.sv
// Shared SRAM read port: the shifter cell drives strobe and address, the SRAM
// answers with read data one cycle later.
interface j_acc_shifter_mx_cell_if #(
  parameter int SRAM_ADDR_W = 18
);
  logic                   sram_en;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [31:0]            sram_rdata;

  modport master (output sram_en, output sram_addr, input  sram_rdata);
  modport slave  (input  sram_en, input  sram_addr, output sram_rdata);
endinterface

// File: rtl/j_acc_shifter_mx_cell.sv
// 32-lane SRAM-to-serial shifter: round-robin word fetches feed per-lane 32-bit
// shift registers that stream LSB first, lane i trailing lane 0 by i cycles.
module j_acc_shifter_mx_cell #(
  parameter int SRAM_DEPTH  = 256*256*4,
  parameter int SRAM_ADDR_W = $clog2(SRAM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  j_acc_shifter_mx_cell_if.master   sram,
  input  logic                      shift_start,
  output logic                      shift_start_o,
  output logic                      shift_idle,
  input  logic [SRAM_ADDR_W*32-1:0] start_addr,
  input  logic [SRAM_ADDR_W-1:0]    img_size,
  output logic [31:0]               serial_out,
  output logic [31:0]               serial_en
);
  localparam int LANES = 32;

  typedef logic [SRAM_ADDR_W-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e      state, state_nxt;
  addr_t       base_q [LANES];
  addr_t       n_q;
  logic [4:0]  lane_sel, lane_nxt;
  addr_t       word_cnt, word_nxt;
  logic        en_d;
  addr_t       addr_d;
  logic        rd_valid;
  logic [4:0]  rd_lane;
  logic [31:0] shreg   [LANES];
  logic [5:0]  bit_cnt [LANES];
  logic [LANES-1:0] start_dly;
  logic        start_ok;
  logic        last_fetch;

  assign start_ok   = (state == IDLE) && shift_start && (img_size != '0);
  assign last_fetch = (lane_sel == 5'd31) && (word_cnt == n_q - addr_t'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Lane 31 is done once its counter is on the final bit and no reload is in flight.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok)   state_nxt = FETCH;
      FETCH:   if (last_fetch) state_nxt = DRAIN;
      DRAIN:   if (bit_cnt[LANES-1] == 6'd1 && !rd_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    lane_nxt = lane_sel;
    word_nxt = word_cnt;
    en_d     = 1'b0;
    addr_d   = sram.sram_addr;
    unique case (state)
      IDLE: if (start_ok) begin
        lane_nxt = '0;
        word_nxt = '0;
        en_d     = 1'b1;
        addr_d   = start_addr[SRAM_ADDR_W-1:0];
      end
      FETCH: if (!last_fetch) begin
        lane_nxt = lane_sel + 5'd1;
        if (lane_sel == 5'd31) word_nxt = word_cnt + addr_t'(1);
        en_d     = 1'b1;
        addr_d   = base_q[lane_nxt] + word_nxt;
      end
      default: ;
    endcase
  end

  // NOTE: the start-time configuration carries no reset; it is always written before use.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      n_q <= img_size;
      for (int i = 0; i < LANES; i++) base_q[i] <= start_addr[i*SRAM_ADDR_W +: SRAM_ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_sel       <= '0;
      word_cnt       <= '0;
      sram.sram_en   <= 1'b0;
      sram.sram_addr <= '0;
      rd_valid       <= 1'b0;
      rd_lane        <= '0;
      start_dly      <= '0;
    end else begin
      lane_sel       <= lane_nxt;
      word_cnt       <= word_nxt;
      sram.sram_en   <= en_d;
      sram.sram_addr <= addr_d;
      rd_valid       <= sram.sram_en;
      rd_lane        <= lane_sel;
      start_dly      <= {start_dly[LANES-2:0], shift_start};
    end
  end

  assign shift_start_o = start_dly[LANES-1];
  assign shift_idle    = (state == IDLE);

  // A reload lands on the cycle the previous word's last bit leaves, keeping lanes gapless.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (reset) begin
        shreg[i]   <= '0;
        bit_cnt[i] <= '0;
      end else if (rd_valid && rd_lane == 5'(i)) begin
        shreg[i]   <= sram.sram_rdata;
        bit_cnt[i] <= 6'd32;
      end else if (bit_cnt[i] != '0) begin
        shreg[i]   <= {1'b0, shreg[i][31:1]};
        bit_cnt[i] <= bit_cnt[i] - 6'd1;
      end
    end
  end

  always_comb begin
    serial_en  = '0;
    serial_out = '0;
    for (int i = 0; i < LANES; i++) begin
      serial_en[i]  = (bit_cnt[i] != '0);
      serial_out[i] = (bit_cnt[i] != '0) & shreg[i][0];
    end
  end
endmodule

// File: tb/tb_j_acc_shifter_mx_cell.sv
// Self-checking bench for j_acc_shifter_mx_cell: cycle-indexed reference model of
// fetch order, per-lane bit streams, idle window and start chaining.
module tb_j_acc_shifter_mx_cell;
  localparam int SRAM_DEPTH = 256*256*4;
  localparam int W          = $clog2(SRAM_DEPTH);
  localparam int LANES      = 32;

  typedef logic [W-1:0] addr_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              shift_start = 1'b0;
  logic              shift_start_o;
  logic              shift_idle;
  logic [W*32-1:0]   start_addr = '0;
  addr_t             img_size = '0;
  logic [31:0]       serial_out;
  logic [31:0]       serial_en;

  always #5 clk = ~clk;

  j_acc_shifter_mx_cell_if #(.SRAM_ADDR_W(W)) bus ();

  j_acc_shifter_mx_cell #(.SRAM_DEPTH(SRAM_DEPTH), .SRAM_ADDR_W(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .sram          (bus),
    .shift_start   (shift_start),
    .shift_start_o (shift_start_o),
    .shift_idle    (shift_idle),
    .start_addr    (start_addr),
    .img_size      (img_size),
    .serial_out    (serial_out),
    .serial_en     (serial_en)
  );

  logic [31:0] mem [addr_t];
  addr_t       base_m [LANES];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] mem_rd(addr_t a);
    if (mem.exists(a)) return mem[a];
    return 32'h9E37_79B9 * {14'd0, a} + 32'h0BAD_F00D;
  endfunction

  // SRAM model: data valid exactly one cycle after the strobe.
  always @(posedge clk) if (bus.sram_en) bus.sram_rdata <= mem_rd(bus.sram_addr);

  function automatic addr_t lane_addr(int lane, int k);
    return addr_t'(int'(base_m[lane]) + k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input int n);
    for (int i = 0; i < LANES; i++) start_addr[i*W +: W] = base_m[i];
    img_size = addr_t'(n);
  endtask

  task automatic random_bases_and_data(input int n);
    mem.delete();
    for (int i = 0; i < LANES; i++) base_m[i] = addr_t'($urandom);
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < n; k++) mem[lane_addr(i, k)] = $urandom;
  endtask

  // Expected outputs in cycle t of a run started at cycle 0 with N = n.
  task automatic check_cycle(input int t, input int n, input int restart_at);
    logic [31:0] exp_en;
    logic [31:0] exp_out;
    logic [31:0] w;
    logic        exp_sram;
    int          j;
    int          idx;
    exp_en   = '0;
    exp_out  = '0;
    exp_sram = (t >= 1 && t <= 32*n);
    check($sformatf("c%0d sram_en", t), 64'(bus.sram_en), 64'(exp_sram));
    if (exp_sram) begin
      idx = t - 1;
      check($sformatf("c%0d sram_addr", t), 64'(bus.sram_addr), 64'(lane_addr(idx % 32, idx / 32)));
    end
    for (int i = 0; i < LANES; i++) begin
      j = t - 3 - i;
      if (j >= 0 && j < 32*n) begin
        exp_en[i]  = 1'b1;
        w          = mem_rd(lane_addr(i, j / 32));
        exp_out[i] = w[j % 32];
      end
    end
    check($sformatf("c%0d serial_en", t), 64'(serial_en), 64'(exp_en));
    check($sformatf("c%0d serial_out", t), 64'(serial_out), 64'(exp_out));
    check($sformatf("c%0d shift_idle", t), 64'(shift_idle), 64'(n == 0 || t == 0 || t >= 32*n + 34));
    check($sformatf("c%0d shift_start_o", t), 64'(shift_start_o),
          64'(t == 32 || (restart_at >= 0 && t == restart_at + 32)));
  endtask

  // One run: start at cycle 0, optional ignored restart, optional abort by reset.
  task automatic run_case(input int n, input int restart_at, input int reset_at);
    int reads;
    int last;
    reads = 0;
    setup(n);
    last = (reset_at >= 0) ? reset_at : ((n == 0) ? 40 : 32*n + 35);
    for (int t = 0; t <= last; t++) begin
      @(negedge clk);
      check_cycle(t, n, restart_at);
      if (bus.sram_en) reads++;
      shift_start = (t == 0 || t == restart_at);
      if (t == restart_at) begin
        img_size = addr_t'($urandom_range(1, 7));
        for (int i = 0; i < LANES; i++) start_addr[i*W +: W] = addr_t'($urandom);
      end
      reset = (t == reset_at);
    end
    if (reset_at >= 0) begin
      for (int t = reset_at + 1; t <= reset_at + 6; t++) begin
        @(negedge clk);
        shift_start = 1'b0;
        reset = 1'b0;
        check($sformatf("rst c%0d sram_en", t), 64'(bus.sram_en), 64'(0));
        check($sformatf("rst c%0d serial_en", t), 64'(serial_en), 64'(0));
        check($sformatf("rst c%0d serial_out", t), 64'(serial_out), 64'(0));
        check($sformatf("rst c%0d shift_idle", t), 64'(shift_idle), 64'(1));
        check($sformatf("rst c%0d shift_start_o", t), 64'(shift_start_o), 64'(0));
        if (bus.sram_en) reads++;
      end
      check("read_count_abort", 64'(reads), 64'(reset_at));
    end else begin
      check($sformatf("read_count_n%0d", n), 64'(reads), 64'(32*n));
    end
  endtask

  task automatic plan_n1_bases;
    mem.delete();
    for (int i = 0; i < LANES; i++) begin
      base_m[i] = addr_t'(i * 16);
      mem[base_m[i]] = 32'hA5A5_0000 | 32'(i);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset sram_en", 64'(bus.sram_en), 64'(0));
    check("reset sram_addr", 64'(bus.sram_addr), 64'(0));
    check("reset shift_idle", 64'(shift_idle), 64'(1));
    check("reset shift_start_o", 64'(shift_start_o), 64'(0));
    check("reset serial_out", 64'(serial_out), 64'(0));
    check("reset serial_en", 64'(serial_en), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // N=1, lane i at i*16 holding 0xA5A5_0000|i.
    plan_n1_bases();
    run_case(1, -1, -1);

    // N=2, lane 0 streams 0xFFFFFFFF then 0x00000001.
    random_bases_and_data(2);
    base_m[0] = addr_t'(100);
    mem[addr_t'(100)] = 32'hFFFF_FFFF;
    mem[addr_t'(101)] = 32'h0000_0001;
    run_case(2, -1, -1);

    // Address wrap on lane 5.
    random_bases_and_data(2);
    base_m[5] = '1;
    mem[addr_t'('1)] = 32'h1357_9BDF;
    mem[addr_t'(0)]  = 32'hCAFE_F00D;
    run_case(2, -1, -1);

    // Restart and img_size/start_addr changes at cycle 10 are ignored.
    plan_n1_bases();
    run_case(1, 10, -1);

    // Reset at cycle 20 of an N=4 run, then a fresh N=1 run.
    random_bases_and_data(4);
    run_case(4, -1, 20);
    plan_n1_bases();
    run_case(1, -1, -1);

    // N=0: no reads, stays idle, chain pulse still at cycle 32.
    random_bases_and_data(1);
    run_case(0, -1, -1);

    // Randomized runs.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 3);
      random_bases_and_data(n);
      run_case(n, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
